// File: rtl/float16_pkg.sv
// Shared binary16 constants, the packed fp16 layout and a signed-infinity helper
// for the float16 MAC datapath.
package float16_pkg;

  localparam int          FP16_EXP_BIAS = 15;
  localparam int          FP16_EXP_W    = 5;
  localparam int          FP16_MAN_W    = 10;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

  function automatic fp16_t fp16_inf(input logic sign);
    fp16_inf = fp16_t'(FP16_POS_INF | {sign, 15'd0});
  endfunction

endpackage

// File: rtl/sig_norm_round_if.sv
// Valid/ready bus between the significand add stage, sig_norm_round and the
// accumulator column.
interface sig_norm_round_if;
  logic               DVI;
  logic               RDY;
  logic               SIGN;
  logic signed [41:0] SUM_OF_SIGNIFICANDS;
  logic signed [7:0]  EXP_IN;
  logic               DVO;
  logic               RDI;
  logic [15:0]        RESULT;

  modport master (
    output DVI, SIGN, SUM_OF_SIGNIFICANDS, EXP_IN, RDI,
    input  RDY, DVO, RESULT
  );

  modport slave (
    input  DVI, SIGN, SUM_OF_SIGNIFICANDS, EXP_IN, RDI,
    output RDY, DVO, RESULT
  );
endinterface

// File: rtl/lzc42.sv
// Leading-one detector for the 41 used bits of the significand sum: highest set
// bit index and an all-zero flag.
module lzc42 (
  input  logic [40:0] vec_i,
  output logic [5:0]  pos_o,
  output logic        zero_o
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    pos_o = 6'd0;
    for (int i = 0; i < 41; i++) begin
      pos_o = vec_i[i] ? 6'(i) : pos_o;
    end
    zero_o = (vec_i == 41'd0);
  end

endmodule

// File: rtl/sig_norm_round.sv
// Three-stage normalise / round-to-nearest-even / pack to binary16 with valid/ready.
// SIG_NORM_SUBNORM_EN enables gradual underflow; otherwise E <= 0 flushes to signed zero.
module sig_norm_round
  import float16_pkg::*;
#(
  parameter int HIDDEN_POS = 30
) (
  input logic            CLK,
  input logic            RST,
  sig_norm_round_if.slave bus
);

  logic v1_q, v2_q, v3_q;
  logic ld1_s, ld2_s, ld3_s;

  // Stage k loads when empty or when the stage after it moves on.
  assign ld3_s   = !v3_q || bus.RDI;
  assign ld2_s   = !v2_q || ld3_s;
  assign ld1_s   = !v1_q || ld2_s;
  assign bus.RDY = ld1_s;

  logic [40:0] sum_in_s;
  logic        unused_sum_msb;
  logic [5:0]  p_s;
  logic        zero_s;

  assign sum_in_s       = bus.SUM_OF_SIGNIFICANDS[40:0];
  assign unused_sum_msb = bus.SUM_OF_SIGNIFICANDS[41];

  lzc42 u_lzc (.vec_i(sum_in_s), .pos_o(p_s), .zero_o(zero_s));

  logic [5:0]        p1_q;
  logic [40:0]       sum1_q;
  logic              sign1_q, zero1_q;
  logic signed [7:0] exp1_q;

  // Stage 2: unbiased position, left-align, extract mantissa/guard/sticky.
  logic signed [9:0] e_s;
  logic [40:0]       norm_s;
  logic [9:0]        e2_d, m2_d;
  logic              g2_d, s2_d, flush2_d;
`ifdef SIG_NORM_SUBNORM_EN
  logic signed [9:0] sh_s;
  logic [3:0]        sh_c_s;
  logic [23:0]       den_s;
`endif

  // Exponent and alignment for the value held in stage 1.
  always_comb begin
    e_s      = {{2{exp1_q[7]}}, exp1_q} + {4'd0, p1_q} - 10'(HIDDEN_POS);
    norm_s   = sum1_q << (6'd40 - p1_q);
    m2_d     = norm_s[39:30];
    g2_d     = norm_s[29];
    s2_d     = |norm_s[28:0];
    e2_d     = e_s;
    flush2_d = 1'b0;
`ifdef SIG_NORM_SUBNORM_EN
    // Denormalise {1, m, g}; shifts of 12 or more leave only sticky.
    sh_s   = 10'sd1 - e_s;
    sh_c_s = (sh_s > 10'sd12) ? 4'd12 : sh_s[3:0];
    den_s  = {1'b1, norm_s[39:29], 12'd0} >> sh_c_s;
    if (e_s <= 10'sd0) begin
      m2_d = den_s[22:13];
      g2_d = den_s[12];
      s2_d = s2_d | (|den_s[11:0]);
      e2_d = 10'd0;
    end else begin
      e2_d = e_s;
    end
`else
    if (e_s <= 10'sd0) begin
      flush2_d = 1'b1;
    end else begin
      flush2_d = 1'b0;
    end
`endif
  end

  logic [9:0] e2_q, m2_q;
  logic       g2_q, s2_q, sign2_q, zero2_q, flush2_q;

  // Stage 3: RNE; mantissa carry-out bumps the exponent field.
  logic        inc_s;
  logic [10:0] mr_s;
  logic [9:0]  ef_s;
  fp16_t       res_d;

  // Round, detect overflow and pack.
  always_comb begin
    inc_s = g2_q & (s2_q | m2_q[0]);
    mr_s  = {1'b0, m2_q} + {10'd0, inc_s};
    ef_s  = e2_q + {9'd0, mr_s[10]};
    res_d = fp16_t'(16'h0000);
    if (zero2_q) begin
      res_d = fp16_t'(16'h0000);
    end else if (flush2_q) begin
      res_d = fp16_t'({sign2_q, 15'd0});
    end else if (ef_s >= 10'd31) begin
      res_d = fp16_inf(sign2_q);
    end else begin
      res_d.sign = sign2_q;
      res_d.exp  = ef_s[4:0];
      res_d.man  = mr_s[9:0];
    end
  end

  fp16_t result_q;

  // Valid bits and all stage registers; data loads only with a valid load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      p1_q     <= 6'd0;
      sum1_q   <= 41'd0;
      sign1_q  <= 1'b0;
      zero1_q  <= 1'b0;
      exp1_q   <= 8'sd0;
      e2_q     <= 10'd0;
      m2_q     <= 10'd0;
      g2_q     <= 1'b0;
      s2_q     <= 1'b0;
      sign2_q  <= 1'b0;
      zero2_q  <= 1'b0;
      flush2_q <= 1'b0;
      result_q <= fp16_t'(16'h0000);
    end else begin
      if (ld1_s) v1_q <= bus.DVI;
      if (ld2_s) v2_q <= v1_q;
      if (ld3_s) v3_q <= v2_q;
      if (ld1_s && bus.DVI) begin
        p1_q    <= p_s;
        sum1_q  <= sum_in_s;
        sign1_q <= bus.SIGN;
        zero1_q <= zero_s;
        exp1_q  <= bus.EXP_IN;
      end
      if (ld2_s && v1_q) begin
        e2_q     <= e2_d;
        m2_q     <= m2_d;
        g2_q     <= g2_d;
        s2_q     <= s2_d;
        sign2_q  <= sign1_q;
        zero2_q  <= zero1_q;
        flush2_q <= flush2_d;
      end
      if (ld3_s && v2_q) begin
        result_q <= res_d;
      end
    end
  end

  assign bus.DVO    = v3_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_sig_norm_round.sv
// Self-checking bench for sig_norm_round: directed unit values, backpressure,
// mid-operation reset and random traffic against a real-arithmetic rounding model.
module tb_sig_norm_round;

  localparam int HP = 30;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sig_norm_round_if bus ();
  sig_norm_round #(.HIDDEN_POS(HP)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic              sgn;
    logic [41:0]       sum;
    logic signed [7:0] ein;
    bit                has_want;
    logic [15:0]       want;
  } stim_t;

  stim_t       in_q[$];
  logic [15:0] exp_q[$];
  int          tin_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  bit          stall_prev = 1'b0;
  logic [15:0] stall_res;
  bit          saw_rdy_low;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Value = sum * 2^(EXP_IN - 15 - HP), rounded to nearest-even binary16.
  function automatic logic [15:0] ref_fp16(input logic sgn, input logic [41:0] sum,
                                           input logic signed [7:0] ein);
    real v, t, units, frac;
    int  e, q, n;
    v = 0.0;
    for (int i = 40; i >= 0; i--) v = v * 2.0 + (sum[i] ? 1.0 : 0.0);
    if (v == 0.0) return 16'h0000;
    v = v * pow2(int'(ein) - 15 - HP);
    t = v;
    e = 0;
    while (t >= 2.0) begin t = t / 2.0; e++; end
    while (t < 1.0) begin t = t * 2.0; e--; end
`ifdef SIG_NORM_SUBNORM_EN
    q = (e < -14) ? -14 : e;
`else
    if (e < -14) return {sgn, 15'd0};
    q = e;
`endif
    units = v * pow2(10 - q);
    n = $rtoi(units);
    frac = units - $itor(n);
    if (frac > 0.5 || (frac == 0.5 && (n % 2) == 1)) n++;
    if (n == 2048) begin n = 1024; q++; end
    if (q + 15 >= 31) return {sgn, 15'h7C00};
    return {sgn, 15'((q + 14) * 1024 + n)};
  endfunction

  function automatic stim_t rand_stim();
    stim_t       st;
    int          p;
    logic [41:0] r, msk;
    r   = {10'($urandom), 32'($urandom)};
    p   = $urandom_range(40, 0);
    msk = (42'd1 << p) - 42'd1;
    st.sum = (r & msk) | (42'd1 << p) | {r[41], 41'd0};
    if (p >= 11 && $urandom_range(3, 0) == 0) st.sum = st.sum & ~((42'd1 << (p - 11)) - 42'd1);
    if ($urandom_range(19, 0) == 0) st.sum = {r[41], 41'd0};
    if ($urandom_range(3, 0) == 0) st.ein = 8'($urandom);
    else st.ein = 8'(int'($urandom_range(50, 0)) - 16 + HP - p);
    st.sgn      = 1'($urandom);
    st.has_want = 1'b0;
    st.want     = 16'h0000;
    return st;
  endfunction

  task automatic add_dir(input logic s, input logic [41:0] sum, input logic signed [7:0] e,
                         input logic [15:0] w);
    stim_t st;
    st.sgn = s; st.sum = sum; st.ein = e; st.has_want = 1'b1; st.want = w;
    in_q.push_back(st);
  endtask

  // One clock: drive at the falling edge, settle, check, account transfers.
  task automatic step(input bit rdi, input bit dvi_en);
    int t;
    @(negedge CLK);
    bus.RDI = rdi;
    if (dvi_en && in_q.size() > 0) begin
      bus.DVI = 1'b1;
      bus.SIGN = in_q[0].sgn;
      bus.SUM_OF_SIGNIFICANDS = in_q[0].sum;
      bus.EXP_IN = in_q[0].ein;
    end else begin
      bus.DVI = 1'b0;
    end
    #1;
    if (stall_prev) begin
      chk_eq("hold_dvo", 32'(bus.DVO), 32'd1);
      chk_eq("hold_result", 32'(bus.RESULT), 32'(stall_res));
    end
    chk_eq("rdy", 32'(bus.RDY), 32'(!(exp_q.size() == 3 && !rdi)));
    if (!bus.RDY) saw_rdy_low = 1'b1;
    if (exp_q.size() == 0) chk_eq("dvo_idle", 32'(bus.DVO), 32'd0);
    if (bus.DVO && rdi && exp_q.size() > 0) begin
      chk_eq("result", 32'(bus.RESULT), 32'(exp_q.pop_front()));
      t = tin_q.pop_front();
      if (chk_lat) chk_eq("latency", 32'(cyc - t), 32'd3);
    end
    if (bus.DVI && bus.RDY) begin
      exp_q.push_back(in_q[0].has_want ? in_q[0].want
                                        : ref_fp16(in_q[0].sgn, in_q[0].sum, in_q[0].ein));
      tin_q.push_back(cyc);
      void'(in_q.pop_front());
    end
    stall_prev = bus.DVO && !rdi;
    stall_res  = bus.RESULT;
    @(posedge CLK);
    cyc++;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    RST = 1'b1;
    bus.DVI = 1'b0; bus.RDI = 1'b0; bus.SIGN = 1'b0;
    bus.SUM_OF_SIGNIFICANDS = 42'd0; bus.EXP_IN = 8'sd0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_eq("rst_dvo", 32'(bus.DVO), 32'd0);
    chk_eq("rst_result", 32'(bus.RESULT), 32'd0);
    chk_eq("rst_rdy", 32'(bus.RDY), 32'd1);

    // Directed values, back-to-back with no stalls.
    add_dir(1'b0, 42'd1 << 30, 8'sd15, 16'h3C00);
    add_dir(1'b1, 42'd3 << 29, 8'sd15, 16'hBE00);
    add_dir(1'b0, (42'd1 << 30) | (42'd1 << 19), 8'sd15, 16'h3C00);
    add_dir(1'b0, (42'd1 << 30) | (42'd1 << 20) | (42'd1 << 19), 8'sd15, 16'h3C02);
    add_dir(1'b0, (42'd1 << 30) | (42'd1 << 19) | 42'd1, 8'sd15, 16'h3C01);
    add_dir(1'b0, 42'd1 << 40, 8'sd30, 16'h7C00);
    add_dir(1'b1, 42'd0, 8'sd15, 16'h0000);
    add_dir(1'b0, (42'h7FF << 20) | 42'hFFFFF, 8'sd30, 16'h7C00);
    add_dir(1'b0, 42'h7FF << 20, 8'sd30, 16'h7BFF);
    add_dir(1'b0, (42'd1 << 41) | (42'd1 << 30), 8'sd15, 16'h3C00);
    add_dir(1'b1, 42'd1, 8'sd45, 16'hBC00);
`ifdef SIG_NORM_SUBNORM_EN
    add_dir(1'b0, 42'd1 << 30, -8'sd5, 16'h0010);
    add_dir(1'b1, 42'd1 << 30, -8'sd5, 16'h8010);
    add_dir(1'b0, (42'h7FF << 20) | (42'd1 << 19), 8'sd0, 16'h0400);
`else
    add_dir(1'b0, 42'd1 << 30, -8'sd5, 16'h0000);
    add_dir(1'b1, 42'd1 << 30, -8'sd5, 16'h8000);
    add_dir(1'b0, (42'h7FF << 20) | (42'd1 << 19), 8'sd0, 16'h0000);
`endif
    chk_lat = 1'b1;
    k = 0;
    while (in_q.size() > 0 && k < 100) begin step(1'b1, 1'b1); k++; end
    drain();

    // Backpressure: 5 inputs streamed, RDI low for cycles 2..8.
    chk_lat = 1'b0;
    saw_rdy_low = 1'b0;
    for (int i = 0; i < 5; i++) in_q.push_back(rand_stim());
    for (int c = 0; c < 14; c++) step(!(c >= 2 && c <= 8), 1'b1);
    drain();
    chk_eq("bp_rdy_fell", 32'(saw_rdy_low), 32'd1);

    // Reset with two results in flight.
    in_q.push_back(rand_stim());
    in_q.push_back(rand_stim());
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge CLK);
    RST = 1'b1; bus.DVI = 1'b0;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    #1;
    chk_eq("midrst_dvo", 32'(bus.DVO), 32'd0);
    chk_eq("midrst_result", 32'(bus.RESULT), 32'd0);
    RST = 1'b0;
    exp_q.delete(); tin_q.delete(); in_q.delete();
    stall_prev = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    chk_lat = 1'b1;
    add_dir(1'b1, 42'd3 << 29, 8'sd15, 16'hBE00);
    step(1'b1, 1'b1);
    drain();

    // Random traffic with random stalls.
    chk_lat = 1'b0;
    for (int i = 0; i < 400; i++) in_q.push_back(rand_stim());
    k = 0;
    while (in_q.size() > 0 && k < 5000) begin
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8);
      k++;
    end
    chk_eq("random_fed", 32'(in_q.size()), 32'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sig_norm_round.md
# sig_norm_round

Pipelined normalise/round/pack stage directly downstream of the significand add/abs stage in the float16 MAC datapath. Takes the sign and 42-bit non-negative significand sum plus the biased exponent of the largest operand, finds the leading one, normalises, rounds to nearest-even and packs an IEEE-754 binary16 result. Three register stages with a valid/ready handshake, so the accumulator column can stall without losing results.

## Interface
- `HIDDEN_POS`, default 30: bit of `SUM_OF_SIGNIFICANDS` that carries weight 2^0 relative to `EXP_IN`.
- `CLK`, input, 1: clock; all logic is on its rising edge.
- `RST`, input, 1: reset, synchronous, active-high.
- `DVI`, input, 1: input data valid.
- `RDY`, output, 1: stage can accept input this cycle.
- `SIGN`, input, 1: sign of the sum.
- `SUM_OF_SIGNIFICANDS`, input, 42, signed: magnitude of the sum; only bits [40:0] are used and bit 41 is ignored.
- `EXP_IN`, input, 8, signed: biased exponent (bias 15) of the largest operand.
- `DVO`, output, 1: result valid.
- `RDI`, input, 1: downstream ready.
- `RESULT`, output, 16: binary16 result.

## Operation
- Transfer in: `DVI && RDY`. Transfer out: `DVO && RDI`.
- Stage 1, LZC:
  - p = index of the leading one in [40:0].
  - Zero flag when [40:0] == 0.
  - Registers p, sum, SIGN and EXP_IN.
- Stage 2, shift and exponent:
  - E = EXP_IN + p − HIDDEN_POS, computed as 10-bit signed with no wrap.
  - Left-align the leading one to a 41-bit frame.
  - Mantissa m = 10 bits below the leading one; guard g = next bit; sticky s = OR of all lower bits.
  - If E ≤ 0 and subnormals are enabled:
    - Shift {1, m} right by (1 − E), folding shifted-out bits into g and s.
    - A shift of ≥ 12 places everything into s.
    - Exponent field = 0.
- Stage 3, round and pack:
  - RNE: increment when g && (s || lsb).
  - Mantissa carry-out increments the exponent field. A subnormal that rounds up becomes 0x0400 | sign.
  - Final exponent ≥ 31 → ±Inf (0x7C00 / 0xFC00).
  - Zero flag → +0 (0x0000) regardless of SIGN.
- NaN and Inf inputs are not represented and are not handled here.

## Timing
- Latency: 3 cycles from input transfer to `DVO`, with no stalls.
- Throughput: 1 result per cycle.
- Per-stage valid bit v[k]. Stage k loads when !v[k] || ready[k+1], where ready[4] = `RDI`.
- `RDY` = !v[1] || (stage 1 advances).
- Stall hold: while `DVO && !RDI`, `RESULT` and `DVO` hold stable.
- Full pipeline: 3 results held; `RDY` is low only when all three stages are full and `RDI` is low.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both accepted.
- Ordering: results leave strictly in input order; there is no drop or duplication.
- Reset values:
  - `DVO` = 0, `RESULT` = 0x0000.
  - All v[k] = 0.
  - `RDY` = 1 from the first cycle after reset deasserts.
- Reset mid-operation: all in-flight results are discarded and no `DVO` is raised for them.
- Data registers load only when their stage loads.

## Configuration
- Macro: `SIG_NORM_SUBNORM_EN`.
- Defined: E ≤ 0 produces gradual underflow (subnormal or rounded-up normal) as described in Operation.
- Undefined: E ≤ 0 flushes to signed zero (SIGN, 15'b0). Stage 2 has no denormalising shifter.

## Structure
- Shared package `float16_pkg`, holding:
  - Constants `FP16_EXP_BIAS` = 15, `FP16_EXP_W` = 5, `FP16_MAN_W` = 10, `FP16_POS_INF` = 16'h7C00.
  - Typedef `fp16_t`, a packed struct of sign, exp[4:0] and man[9:0].
- Sub-module `lzc42`: combinational leading-one position of a 41-bit vector, giving a 6-bit index and a zero flag. Instantiated in stage 1.

## Test plan
- Unit values:
  - Sum 1<<30, EXP_IN 15, SIGN 0 → 0x3C00 after 3 cycles.
  - Sum 3<<29, EXP_IN 15, SIGN 1 → 0xBE00.
- Ties and round-up:
  - Sum (1<<30)|(1<<19), EXP_IN 15 → 0x3C00 (tie, even).
  - Sum (1<<30)|(1<<20)|(1<<19) → 0x3C02.
  - Sum (1<<30)|(1<<19)|1 → 0x3C01.
- Extremes:
  - Sum 1<<40, EXP_IN 30 → 0x7C00.
  - Sum 0, SIGN 1 → 0x0000.
  - Sum 0x7FF<<20 with the low 20 bits set, EXP_IN 30 → rounds to 0x7C00.
- Underflow:
  - Sum 1<<30, EXP_IN −5 → 0x0010 with `SIG_NORM_SUBNORM_EN`, 0x0000 without.
  - Sum 0x7FF<<20 with bit 19 set, EXP_IN 0 → 0x0400 with the macro.
- Backpressure:
  - Stream 5 inputs back-to-back with `RDI` low for cycles 2–8.
  - `RDY` falls once 3 results are held; outputs arrive in order with no loss.
  - `RESULT` stays stable while stalled.
- Reset: assert `RST` with 2 results in flight → `DVO` stays 0 and `RESULT` = 0x0000 on the next cycle, and the next input completes normally 3 cycles after acceptance.
